// File: rtl/adder_pipe_nbit.sv
// adder_pipe_nbit
//   Pipelined N-bit adder/subtractor with valid/ready stream handshake.
//   The carry chain is cut into NUM_STAGES registered segments of
//   SEG = BIT_WIDTH/NUM_STAGES bits. Stage k adds segment k using the carry
//   registered by stage k-1; operands and finished low sum bits ride along.
//   The whole pipe advances together (adv), so a stalled output freezes
//   every stage and bubbles are not compressed.
//
//   Optional feature macro: ADDER_SAT_EN
//     defined   -> on signed overflow, sum saturates to 0x7F..F / 0x80..0
//     undefined -> sum wraps modulo 2^BIT_WIDTH
//
// Parameters
//   BIT_WIDTH   operand/result width (multiple of NUM_STAGES)
//   NUM_STAGES  pipeline segments, 1..BIT_WIDTH
// Ports
//   clk        in   rising-edge clock
//   n_rst      in   asynchronous active-low reset
//   a, b       in   operands
//   carry_in   in   carry into bit 0 (add mode only)
//   sub        in   1: a-b (a + ~b + 1), carry_in ignored
//   in_valid   in   operand beat valid
//   in_ready   out  operand beat accepted this cycle
//   sum        out  result
//   carry_out  out  carry out of MSB (sub: 1 = no borrow)
//   overflow   out  signed overflow
//   out_valid  out  result beat valid
//   out_ready  in   consumer accepts result beat
module adder_pipe_nbit #(
   parameter int BIT_WIDTH  = 16,
   parameter int NUM_STAGES = 4
) (
   input  logic                 clk,
   input  logic                 n_rst,
   input  logic [BIT_WIDTH-1:0] a,
   input  logic [BIT_WIDTH-1:0] b,
   input  logic                 carry_in,
   input  logic                 sub,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BIT_WIDTH-1:0] sum,
   output logic                 carry_out,
   output logic                 overflow,
   output logic                 out_valid,
   input  logic                 out_ready
);

   localparam int SEG  = BIT_WIDTH / NUM_STAGES;
   localparam int LAST = NUM_STAGES - 1;

   logic                  adv;

   // Stage registers
   logic [BIT_WIDTH-1:0]  a_q [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  b_q [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  s_q [NUM_STAGES];
   logic [NUM_STAGES-1:0] c_q;
   logic [NUM_STAGES-1:0] v_q;

   // Stage inputs (port side for stage 0, previous register otherwise)
   logic [BIT_WIDTH-1:0]  in_a [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  in_b [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  in_s [NUM_STAGES];
   logic [NUM_STAGES-1:0] in_c;
   logic [NUM_STAGES-1:0] in_v;

   // Next-state values
   logic [BIT_WIDTH-1:0]  a_d [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  b_d [NUM_STAGES];
   logic [BIT_WIDTH-1:0]  s_d [NUM_STAGES];
   logic [NUM_STAGES-1:0] c_d;
   logic [NUM_STAGES-1:0] v_d;
   logic [SEG:0]          seg_sum;

   logic                  msb_cin;

   assign adv      = ~v_q[LAST] | out_ready;
   assign in_ready = adv;

   always_comb begin
      in_a = '{default: '0};
      in_b = '{default: '0};
      in_s = '{default: '0};
      in_c = '0;
      in_v = '0;
      // Subtract is folded in here: invert b and force the stage-0 carry.
      in_a[0] = a;
      in_b[0] = sub ? ~b : b;
      in_c[0] = sub ? 1'b1 : carry_in;
      in_v[0] = in_valid;
      for (int unsigned k = 1; k < NUM_STAGES; k++) begin
         in_a[k] = a_q[k-1];
         in_b[k] = b_q[k-1];
         in_s[k] = s_q[k-1];
         in_c[k] = c_q[k-1];
         in_v[k] = v_q[k-1];
      end
   end

   always_comb begin
      a_d     = '{default: '0};
      b_d     = '{default: '0};
      s_d     = '{default: '0};
      c_d     = '0;
      v_d     = '0;
      seg_sum = '0;
      for (int unsigned k = 0; k < NUM_STAGES; k++) begin
         seg_sum = {1'b0, in_a[k][k*SEG +: SEG]}
                 + {1'b0, in_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, in_c[k]};
         a_d[k]                = in_a[k];
         b_d[k]                = in_b[k];
         s_d[k]                = in_s[k];
         s_d[k][k*SEG +: SEG]  = seg_sum[SEG-1:0];
         c_d[k]                = seg_sum[SEG];
         v_d[k]                = in_v[k];
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            a_q[k] <= '0;
            b_q[k] <= '0;
            s_q[k] <= '0;
         end
         c_q <= '0;
         v_q <= '0;
      end else if (adv) begin
         for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            a_q[k] <= a_d[k];
            b_q[k] <= b_d[k];
            s_q[k] <= s_d[k];
         end
         c_q <= c_d;
         v_q <= v_d;
      end
   end

   // Carry into the MSB is recovered from the MSB sum bit and its operands,
   // so no extra carry needs to be pipelined.
   assign msb_cin   = a_q[LAST][BIT_WIDTH-1] ^ b_q[LAST][BIT_WIDTH-1] ^ s_q[LAST][BIT_WIDTH-1];
   assign overflow  = msb_cin ^ c_q[LAST];
   assign carry_out = c_q[LAST];
   assign out_valid = v_q[LAST];

`ifdef ADDER_SAT_EN
   // On overflow both (post-inversion) operands share a sign; a's MSB picks the rail.
   assign sum = overflow ? {a_q[LAST][BIT_WIDTH-1], {(BIT_WIDTH-1){~a_q[LAST][BIT_WIDTH-1]}}}
                         : s_q[LAST];
`else
   assign sum = s_q[LAST];
`endif

endmodule

// File: tb/tb_adder_pipe_nbit.sv
// tb_adder_pipe_nbit
//   Self-checking bench for adder_pipe_nbit (BIT_WIDTH=16, NUM_STAGES=4).
//   Expected results are queued when a beat is accepted and compared when a
//   result beat is consumed. Honors ADDER_SAT_EN when defined.
module tb_adder_pipe_nbit;

   localparam int W = 16;
   localparam int N = 4;

   typedef struct packed {
      logic [W-1:0] s;
      logic         co;
      logic         ov;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      exp_t         e;
   } vec_t;

   logic         clk;
   logic         n_rst;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         carry_in;
   logic         sub;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] sum;
   logic         carry_out;
   logic         overflow;
   logic         out_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;
   exp_t sb[$];

   logic         smp_valid;
   logic         smp_ready;
   logic [W-1:0] smp_sum;

   adder_pipe_nbit #(.BIT_WIDTH(W), .NUM_STAGES(N)) dut (
      .clk(clk), .n_rst(n_rst), .a(a), .b(b), .carry_in(carry_in), .sub(sub),
      .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .carry_out(carry_out),
      .overflow(overflow), .out_valid(out_valid), .out_ready(out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Independent reference: wide add, sign-rule overflow.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic icin, input logic isub);
      logic [W:0]   full;
      logic [W-1:0] bb;
      exp_t         r;
      bb   = isub ? ~ib : ib;
      full = {1'b0, ia} + {1'b0, bb} + {{W{1'b0}}, (isub ? 1'b1 : icin)};
      r.s  = full[W-1:0];
      r.co = full[W];
      r.ov = (ia[W-1] == bb[W-1]) && (full[W-1] != ia[W-1]);
`ifdef ADDER_SAT_EN
      if (r.ov) r.s = ia[W-1] ? 16'h8000 : 16'h7FFF;
`endif
      return r;
   endfunction

   // One clock: drive at negedge, sample just after, settle handshakes before posedge.
   task automatic cycle(input logic iv, input logic [W-1:0] ia, input logic [W-1:0] ib,
                        input logic icin, input logic isub, input logic iordy, input exp_t ie);
      exp_t e;
      @(negedge clk);
      in_valid = iv; a = ia; b = ib; carry_in = icin; sub = isub; out_ready = iordy;
      #1;
      smp_valid = out_valid;
      smp_ready = in_ready;
      smp_sum   = sum;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out got sum=%0h exp=no_output", sum);
         end else begin
            e = sb.pop_front();
            chk("sum", {16'h0, sum}, {16'h0, e.s});
            chk("carry_out", {31'h0, carry_out}, {31'h0, e.co});
            chk("overflow", {31'h0, overflow}, {31'h0, e.ov});
         end
      end
      if (in_valid && in_ready) sb.push_back(ie);
   endtask

   task automatic idle(input logic iordy);
      cycle(1'b0, '0, '0, 1'b0, 1'b0, iordy, '0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 200) begin
         idle(1'b1);
         n++;
      end
      chk("drain_empty", sb.size(), 0);
   endtask

   vec_t tv[10];

   initial begin
      int           lat;
      int           spur;
      logic [W-1:0] held;
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      logic         rs;

      tv[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, '{16'h0100, 1'b0, 1'b0}};
      tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
`ifdef ADDER_SAT_EN
      tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h7FFF, 1'b0, 1'b1}};
      tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h8000, 1'b1, 1'b1}};
      tv[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h8000, 1'b1, 1'b1}};
`else
      tv[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
      tv[5] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
      tv[7] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
`endif
      tv[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
      tv[4] = '{16'h1234, 16'h4321, 1'b1, 1'b0, '{16'h5556, 1'b0, 1'b0}};
      tv[6] = '{16'h0007, 16'h0005, 1'b0, 1'b1, '{16'h0002, 1'b1, 1'b0}};
      tv[8] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, '{16'h0000, 1'b1, 1'b0}};
      tv[9] = '{16'h0000, 16'h0000, 1'b1, 1'b0, '{16'h0001, 1'b0, 1'b0}};

      n_rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
      out_ready = 1'b0;
      smp_valid = 1'b0; smp_ready = 1'b0; smp_sum = '0;
      #23;
      chk("rst_out_valid", {31'h0, out_valid}, 0);
      chk("rst_sum", {16'h0, sum}, 0);
      chk("rst_in_ready", {31'h0, in_ready}, 1);
      chk("rst_carry_out", {31'h0, carry_out}, 0);
      chk("rst_overflow", {31'h0, overflow}, 0);
      @(negedge clk);
      n_rst = 1'b1;

      // Latency: segment-crossing carry, out_valid exactly N cycles after accept.
      cycle(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, '{16'h0100, 1'b0, 1'b0});
      lat = 0;
      do begin
         idle(1'b1);
         lat++;
      end while (!smp_valid && lat < 50);
      chk("latency", lat, N);
      drain();

      // Directed vectors, back-to-back.
      for (int i = 0; i < 10; i++)
         cycle(1'b1, tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, 1'b1, tv[i].e);
      drain();

      // 8 back-to-back beats, then a 3-cycle stall with in_valid held high.
      for (int i = 0; i < 8; i++) begin
         ra = W'(16'h1111 * (i + 1)); rb = W'(16'h0F00 + i);
         cycle(1'b1, ra, rb, 1'b0, 1'b0, 1'b1, model(ra, rb, 1'b0, 1'b0));
      end
      for (int i = 0; i < 3; i++) begin
         ra = W'(16'hA000 + i);
         cycle(1'b1, ra, 16'h0003, 1'b0, 1'b0, 1'b0, model(ra, 16'h0003, 1'b0, 1'b0));
         if (i == 0) held = smp_sum;
         chk("stall_in_ready", {31'h0, smp_ready}, 0);
         chk("stall_out_valid", {31'h0, smp_valid}, 1);
         chk("stall_sum_held", {16'h0, smp_sum}, {16'h0, held});
      end
      drain();

      // Random stream with random back-pressure.
      for (int i = 0; i < 1000; i++) begin
         ra = W'($urandom); rb = W'($urandom);
         rc = 1'($urandom); rs = 1'($urandom);
         cycle(($urandom_range(3) != 0), ra, rb, rc, rs, ($urandom_range(9) < 7),
               model(ra, rb, rc, rs));
      end
      drain();

      // Reset asserted with operations in flight.
      for (int i = 0; i < 6; i++) begin
         ra = W'(16'h0100 + i);
         cycle(1'b1, ra, 16'h0002, 1'b0, 1'b0, 1'b1, model(ra, 16'h0002, 1'b0, 1'b0));
      end
      chk("pre_reset_out_valid", {31'h0, smp_valid}, 1);
      @(negedge clk);
      #2;
      n_rst = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("midrst_out_valid", {31'h0, out_valid}, 0);
      chk("midrst_sum", {16'h0, sum}, 0);
      chk("midrst_in_ready", {31'h0, in_ready}, 1);
      sb.delete();
      @(negedge clk);
      n_rst = 1'b1;
      spur = 0;
      for (int i = 0; i < 8; i++) begin
         idle(1'b1);
         if (smp_valid) spur++;
      end
      chk("post_reset_spurious", spur, 0);

      // Pipe usable again after reset.
      cycle(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0});
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
